i2s_tx_feeder: RTL and testbench

I2S_TX_FEEDER -- requirements
Module: i2s_tx_feeder

---
 rtl/i2s_pkg.sv | 16 +
 rtl/i2s_sample_fifo.sv | 62 ++++++
 rtl/i2s_tx_feeder.sv | 82 ++++++++
 tb/tb_i2s_tx_feeder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants for the I2S transmit feeder: clock-divider layout,
// frame tick position and default sample width.
package i2s_pkg;

  localparam int DIV_WIDTH       = 8;
  localparam int SCLK_BIT        = 1;
  localparam int LRCLK_BIT       = 7;
  localparam logic [DIV_WIDTH-1:0] FRAME_TICK = 8'hFF;
  localparam int DEFAULT_BIT_NUM = 32;

  // A level counter must hold 0..depth inclusive, hence the extra bit.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Stereo-pair FIFO: power-of-two depth, pointers wrap naturally, level
// counter drives full/empty so every slot is usable.
module i2s_sample_fifo
  import i2s_pkg::*;
#(
  parameter int WIDTH = 2 * DEFAULT_BIT_NUM,
  parameter int DEPTH = 4
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              wr_data,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [level_width(DEPTH)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a write even when a read happens in the same cycle.
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_tx_feeder.sv
// Feeds buffered stereo pairs to an I2S serializer: derives SCLK/LRCLK from
// MCLK and swaps in a new pair at every frame start, zeros on underrun.
module i2s_tx_feeder
  import i2s_pkg::*;
#(
  parameter int bitNum     = DEFAULT_BIT_NUM,
  parameter int FIFO_DEPTH = 4
)(
  input  logic                          MCLK,
  input  logic                          RST,
  input  logic [bitNum-1:0]             IN_L,
  input  logic [bitNum-1:0]             IN_R,
  input  logic                          IN_VALID,
  output logic                          IN_READY,
  output logic                          SCLK,
  output logic                          LRCLK,
  output logic [bitNum-1:0]             DATA_L,
  output logic [bitNum-1:0]             DATA_R,
  output logic                          UNDERRUN,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL
);

  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 frame_tick;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [2*bitNum-1:0]  head_pair;

  // Serial clocks come straight from divider bits so they cannot glitch.
  assign SCLK       = div_cnt[SCLK_BIT];
  assign LRCLK      = div_cnt[LRCLK_BIT];
  assign frame_tick = (div_cnt == FRAME_TICK);
  assign IN_READY   = !fifo_full && !RST;
  assign push       = IN_VALID && IN_READY;
  assign pop        = frame_tick && !fifo_empty;

  i2s_sample_fifo #(
    .WIDTH (2 * bitNum),
    .DEPTH (FIFO_DEPTH)
  ) sample_fifo (
    .clk     (MCLK),
    .rst     (RST),
    .push    (push),
    .pop     (pop),
    .wr_data ({IN_L, IN_R}),
    .rd_data (head_pair),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (LEVEL)
  );

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // The pair loads on the same edge that drops LRCLK, so it is stable for
  // the whole frame; an empty FIFO at that edge plays silence instead.
  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      DATA_L   <= '0;
      DATA_R   <= '0;
      UNDERRUN <= 1'b0;
    end else begin
      UNDERRUN <= frame_tick && fifo_empty;
      if (frame_tick) begin
        if (fifo_empty) begin
          DATA_L <= '0;
          DATA_R <= '0;
        end else begin
          {DATA_L, DATA_R} <= head_pair;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_feeder.sv
// Scoreboard bench for i2s_tx_feeder: stimulus queues the pair expected at
// each LRCLK fall, an independent monitor checks every frame start.
module tb_i2s_tx_feeder;

  typedef struct packed {
    logic        underrun;
    logic [31:0] l;
    logic [31:0] r;
  } frame_t;

  logic        MCLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic [31:0] IN_L = '0;
  logic [31:0] IN_R = '0;
  logic        IN_READY;
  logic        SCLK;
  logic        LRCLK;
  logic [31:0] DATA_L;
  logic [31:0] DATA_R;
  logic        UNDERRUN;
  logic [2:0]  LEVEL;

  frame_t      exp_q[$];
  frame_t      exp_frame;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          clk_err = 0;
  int          npush = 0;
  logic        prev_lr = 1'b0;
  logic [31:0] last_l = '0;
  logic [31:0] last_r = '0;

  always #5 MCLK = ~MCLK;

  i2s_tx_feeder #(
    .bitNum     (32),
    .FIFO_DEPTH (4)
  ) dut (
    .MCLK     (MCLK),
    .RST      (RST),
    .IN_L     (IN_L),
    .IN_R     (IN_R),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .SCLK     (SCLK),
    .LRCLK    (LRCLK),
    .DATA_L   (DATA_L),
    .DATA_R   (DATA_R),
    .UNDERRUN (UNDERRUN),
    .LEVEL    (LEVEL)
  );

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic [31:0] l, input logic [31:0] r);
    IN_VALID = valid;
    IN_L     = l;
    IN_R     = r;
  endtask

  // One MCLK cycle; the divider outputs are checked against the bench's own count.
  task automatic step();
    @(negedge MCLK);
    cyc++;
    if (!RST && (SCLK !== cyc[1] || LRCLK !== cyc[7])) begin
      clk_err++;
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) begin
      step();
    end
  endtask

  task automatic apply_reset();
    #1 RST = 1'b1;
    apply_stimulus(1'b0, 32'hDEADBEEF, 32'hCAFEF00D);
    exp_q.delete();
    @(negedge MCLK);
    @(negedge MCLK);
    check_output("reset_data", {DATA_L, DATA_R}, 64'h0);
    check_output("reset_level", 64'(LEVEL), 64'h0);
    check_output("reset_ready", 64'(IN_READY), 64'h0);
    check_output("reset_clocks", {62'h0, SCLK, LRCLK}, 64'h0);
    check_output("reset_underrun", 64'(UNDERRUN), 64'h0);
    RST     = 1'b0;
    cyc     = 0;
    clk_err = 0;
    #1;
  endtask

  task automatic end_test(input string name);
    check_output({name, "_pending"}, 64'(exp_q.size()), 64'h0);
    check_output({name, "_clocks"}, 64'(clk_err), 64'h0);
  endtask

  // Monitor: every LRCLK fall is a new frame to score; between falls the
  // data must hold and UNDERRUN must stay low.
  initial begin : monitor
    forever begin
      @(negedge MCLK);
      if (RST) begin
        prev_lr = 1'b0;
        last_l  = DATA_L;
        last_r  = DATA_R;
      end else begin
        if (prev_lr && !LRCLK) begin
          if (exp_q.size() > 0) begin
            exp_frame = exp_q.pop_front();
            check_output("frame_data", {DATA_L, DATA_R}, {exp_frame.l, exp_frame.r});
            check_output("frame_underrun", 64'(UNDERRUN), 64'(exp_frame.underrun));
          end
        end else begin
          if (UNDERRUN) begin
            check_output("stray_underrun", 64'(UNDERRUN), 64'h0);
          end
          if (DATA_L !== last_l || DATA_R !== last_r) begin
            check_output("data_hold", {DATA_L, DATA_R}, {last_l, last_r});
          end
        end
        prev_lr = LRCLK;
        last_l  = DATA_L;
        last_r  = DATA_R;
      end
    end
  end

  initial begin : stimulus
    logic will_push;
    logic [31:0] k;

    // Idle after reset: two silent frames.
    apply_reset();
    exp_q.push_back('{1'b1, 32'h0, 32'h0});
    exp_q.push_back('{1'b1, 32'h0, 32'h0});
    run_to(600);
    end_test("idle");

    // Single push at cycle 10, played in the first frame only.
    apply_reset();
    exp_q.push_back('{1'b0, 32'h00000001, 32'hFFFFFFFF});
    exp_q.push_back('{1'b1, 32'h0, 32'h0});
    run_to(10);
    apply_stimulus(1'b1, 32'h00000001, 32'hFFFFFFFF);
    step();
    apply_stimulus(1'b0, 32'h12345678, 32'h9ABCDEF0);
    check_output("single_level_up", 64'(LEVEL), 64'h1);
    run_to(257);
    check_output("single_level_down", 64'(LEVEL), 64'h0);
    run_to(520);
    end_test("single");

    // Continuous producer: fills to 4, then one refill after each pop.
    apply_reset();
    exp_q.push_back('{1'b0, 32'h10000000, 32'hA0000000});
    exp_q.push_back('{1'b0, 32'h10000001, 32'hA0000001});
    exp_q.push_back('{1'b0, 32'h10000002, 32'hA0000002});
    k     = 0;
    npush = 0;
    apply_stimulus(1'b1, 32'h10000000 + k, 32'hA0000000 + k);
    while (cyc < 780) begin
      will_push = IN_READY;
      step();
      if (will_push) begin
        npush++;
        k = k + 1;
        apply_stimulus(1'b1, 32'h10000000 + k, 32'hA0000000 + k);
      end
      if (cyc == 4) begin
        check_output("stream_full_level", 64'(LEVEL), 64'h4);
        check_output("stream_full_ready", 64'(IN_READY), 64'h0);
      end
      if (cyc == 257) begin
        check_output("stream_refill_count", 64'(npush), 64'h5);
      end
    end
    apply_stimulus(1'b0, 32'h0, 32'h0);
    check_output("stream_total_pushes", 64'(npush), 64'h7);
    check_output("stream_end_level", 64'(LEVEL), 64'h4);
    end_test("stream");

    // Push exactly on the frame tick while empty.
    apply_reset();
    exp_q.push_back('{1'b1, 32'h0, 32'h0});
    exp_q.push_back('{1'b0, 32'h55AA00FF, 32'h80000000});
    run_to(255);
    apply_stimulus(1'b1, 32'h55AA00FF, 32'h80000000);
    step();
    apply_stimulus(1'b0, 32'h0, 32'h0);
    check_output("tick_push_level", 64'(LEVEL), 64'h1);
    run_to(520);
    end_test("tick_push");

    // Fill, play three pairs, then reset mid-frame: the last pair must vanish.
    apply_reset();
    exp_q.push_back('{1'b0, 32'h0000AAA0, 32'h0000BBB0});
    exp_q.push_back('{1'b0, 32'h0000AAA1, 32'h0000BBB1});
    exp_q.push_back('{1'b0, 32'h0000AAA2, 32'h0000BBB2});
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 32'h0000AAA0 + 32'(i), 32'h0000BBB0 + 32'(i));
      step();
    end
    apply_stimulus(1'b0, 32'h0, 32'h0);
    check_output("abort_full_level", 64'(LEVEL), 64'h4);
    run_to(896);
    check_output("abort_pre_level", 64'(LEVEL), 64'h1);
    check_output("abort_pre_data", {DATA_L, DATA_R}, {32'h0000AAA2, 32'h0000BBB2});
    end_test("abort_pre");
    #1 RST = 1'b1;
    #1;
    check_output("abort_async_data", {DATA_L, DATA_R}, 64'h0);
    check_output("abort_async_level", 64'(LEVEL), 64'h0);
    check_output("abort_async_lrclk", 64'(LRCLK), 64'h0);
    apply_reset();
    exp_q.push_back('{1'b1, 32'h0, 32'h0});
    exp_q.push_back('{1'b1, 32'h0, 32'h0});
    run_to(520);
    end_test("abort_post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
